fetch_prefetch_queue: RTL and testbench

//  Instruction-fetch front end for the pipelined CPU: generates fetch PCs, issues requests to a

---
 rtl/fetch_prefetch_queue_if.sv | 37 +++
 rtl/fetch_prefetch_queue.sv | 94 +++++++++
 tb/tb_fetch_prefetch_queue.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// rtl/fetch_prefetch_queue_if.sv - fetch front-end bundle: instruction-memory port, redirect and IF/ID stream
interface fetch_prefetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_req;
    logic [63:0]   imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [63:0]   redirect_pc;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [63:0]   out_pc;
    logic          out_ready;
    logic [CW-1:0] count;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output out_valid, out_instr, out_pc,
        input  out_ready,
        output count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  out_valid, out_instr, out_pc,
        output out_ready,
        input  count
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - credit-limited instruction prefetcher with in-order response FIFO and redirect flush
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_prefetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] DEPTH_V = OW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, CREDIT} state_t;

    state_t        state, state_nx;
    logic [63:0]   fetch_pc, rsp_pc;
    logic [CW-1:0] inflight, inflight_nx, drop, count_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   fifo_instr [DEPTH];
    logic [63:0]   fifo_pc    [DEPTH];
    logic [OW-1:0] outstanding;
    logic          gnt_acc, push, pop;

    assign gnt_acc     = (state == REQ) && bus.imem_gnt;
    // A response arriving with a redirect, or while drop is pending, belongs to the old stream.
    assign push        = bus.imem_rvalid && !bus.redirect && (drop == '0);
    assign pop         = bus.out_valid && bus.out_ready;
    assign inflight_nx = inflight + CW'(gnt_acc) - CW'(bus.imem_rvalid);
    assign outstanding = {1'b0, count_q} + {1'b0, inflight};

    assign bus.imem_req  = (state == REQ);
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_instr = fifo_instr[rd_ptr];
    assign bus.out_pc    = fifo_pc[rd_ptr];
    assign bus.count     = count_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = REQ;
            REQ:     if (gnt_acc && (outstanding + OW'(1) >= DEPTH_V)) state_nx = CREDIT;
            CREDIT:  if (outstanding < DEPTH_V) state_nx = REQ;
            default: state_nx = IDLE;
        endcase
        // A full set of cancelled fetches still holds every credit, so wait for them to drain.
        if (bus.redirect)
            state_nx = ({1'b0, inflight_nx} < DEPTH_V) ? REQ : CREDIT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            count_q  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            state    <= state_nx;
            inflight <= inflight_nx;
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc;
                rsp_pc   <= bus.redirect_pc;
                drop     <= inflight_nx;
                count_q  <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (gnt_acc)
                    fetch_pc <= fetch_pc + 64'd4;
                if (bus.imem_rvalid && (drop != '0))
                    drop <= drop - CW'(1);
                if (push) begin
                    fifo_instr[wr_ptr] <= bus.imem_rdata;
                    fifo_pc[wr_ptr]    <= rsp_pc;
                    rsp_pc             <= rsp_pc + 64'd4;
                    wr_ptr             <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed bench with in-order latency memory model and pop-sequence scoreboard
module tb_fetch_prefetch_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } rsp_t;

    typedef struct {
        int          lat;
        logic [63:0] target;
        logic [63:0] e0;
        logic [63:0] e1;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    rsp_t        mq[$];
    logic [63:0] popped[$];
    int          cyc = 0;
    int          lat = 1;
    bit          gnt_en = 1'b1;
    int          grants = 0;
    logic [63:0] exp_pc = 64'h0;
    bit          gnt_now, rvalid_now, hold_prev;
    logic [63:0] prev_addr;
    vec_t        tbl[5];

    function automatic logic [31:0] memfn(logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic check64(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memfn(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end
        bus.imem_gnt = gnt_en;
        gnt_now      = gnt_en && bus.imem_req;
        rvalid_now   = bus.imem_rvalid;
        if (gnt_now) begin
            mq.push_back('{addr: bus.imem_addr, due: cyc + lat});
            grants++;
        end
        if (bus.out_valid && bus.out_ready) begin
            check64("pop_pc", bus.out_pc, exp_pc);
            check64("pop_instr", 64'(bus.out_instr), 64'(memfn(exp_pc)));
            popped.push_back(bus.out_pc);
            exp_pc = exp_pc + 64'd4;
        end
        if (hold_prev)
            check64("addr_hold", bus.imem_addr, prev_addr);
        hold_prev = bus.imem_req && !gnt_en && !bus.redirect;
        prev_addr = bus.imem_addr;
        if (bus.redirect)
            exp_pc = bus.redirect_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 64'h0;
        bus.out_ready   = 1'b0;
        mq.delete();
        popped.delete();
        exp_pc    = 64'h0;
        hold_prev = 1'b0;
        grants    = 0;
        gnt_en    = 1'b1;
        lat       = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_until_pops(string name, int n, int budget);
        for (int k = 0; k < budget && popped.size() < n; k++)
            tick();
        total++;
        if (popped.size() < n) begin
            bad++;
            $display("FAIL %s_timeout: got %0d pops required %0d", name, popped.size(), n);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check64({tag, "_req"},   64'(bus.imem_req), 64'h0);
        check64({tag, "_addr"},  bus.imem_addr, 64'h0);
        check64({tag, "_valid"}, 64'(bus.out_valid), 64'h0);
        check64({tag, "_instr"}, 64'(bus.out_instr), 64'h0);
        check64({tag, "_pc"},    bus.out_pc, 64'h0);
        check64({tag, "_count"}, 64'(bus.count), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{lat: 1, target: 64'h100,                 e0: 64'h100,                 e1: 64'h104};
        tbl[1] = '{lat: 3, target: 64'h200,                 e0: 64'h200,                 e1: 64'h204};
        tbl[2] = '{lat: 2, target: 64'hFFFF_FFFF_FFFF_FFFC, e0: 64'hFFFF_FFFF_FFFF_FFFC, e1: 64'h0};
        tbl[3] = '{lat: 5, target: 64'h1000,                e0: 64'h1000,                e1: 64'h1004};
        tbl[4] = '{lat: 1, target: 64'h8,                   e0: 64'h8,                   e1: 64'hC};

        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 64'h0;
        bus.out_ready   = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // 1-cycle memory, streaming consumer
        do_reset();
        bus.out_ready = 1'b1;
        tick();
        check64("t1_req", 64'(bus.imem_req), 64'h1);
        tick();
        check64("t1_valid_early", 64'(bus.out_valid), 64'h0);
        tick();
        check64("t1_valid", 64'(bus.out_valid), 64'h1);
        check64("t1_first_pc", bus.out_pc, 64'h0);
        repeat (4) tick();
        popped.delete();
        repeat (10) tick();
        check64("t1_throughput", 64'(popped.size()), 64'd10);

        // stalled consumer fills exactly DEPTH entries, then drains in order
        do_reset();
        repeat (12) tick();
        check64("t2_grants", 64'(grants), 64'd4);
        check64("t2_count", 64'(bus.count), 64'd4);
        check64("t2_req", 64'(bus.imem_req), 64'h0);
        bus.out_ready = 1'b1;
        run_until_pops("t2", 5, 40);
        for (int i = 0; i < 5; i++)
            if (i < popped.size())
                check64("t2_seq", popped[i], 64'(i * 4));

        // 3-cycle memory with fetches in flight, then redirect
        do_reset();
        lat = 3;
        bus.out_ready = 1'b1;
        repeat (4) tick();
        check64("t3_no_pop_yet", 64'(popped.size()), 64'd0);
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h100;
        tick();
        bus.redirect = 1'b0;
        popped.delete();
        run_until_pops("t3", 1, 40);
        if (popped.size() > 0)
            check64("t3_first", popped[0], 64'h100);

        // redirect coinciding with both a grant and a response, then back-to-back redirects
        do_reset();
        bus.out_ready = 1'b1;
        repeat (8) tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h200;
        tick();
        check64("t4_coincide", 64'(gnt_now && rvalid_now), 64'h1);
        bus.redirect = 1'b0;
        popped.delete();
        run_until_pops("t4", 2, 30);
        if (popped.size() >= 2) begin
            check64("t4_pc0", popped[0], 64'h200);
            check64("t4_pc1", popped[1], 64'h204);
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h400;
        tick();
        bus.redirect_pc = 64'h500;
        tick();
        bus.redirect = 1'b0;
        popped.delete();
        run_until_pops("t4b", 1, 30);
        if (popped.size() > 0)
            check64("t4_b2b", popped[0], 64'h500);

        // grant withheld: request and address held, redirect moves the address
        do_reset();
        gnt_en = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check64("t5_req", 64'(bus.imem_req), 64'h1);
            check64("t5_addr", bus.imem_addr, 64'h0);
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h300;
        tick();
        bus.redirect = 1'b0;
        check64("t5_redir_addr", bus.imem_addr, 64'h300);
        check64("t5_redir_req", 64'(bus.imem_req), 64'h1);
        gnt_en = 1'b1;
        popped.delete();
        run_until_pops("t5", 1, 20);
        if (popped.size() > 0)
            check64("t5_first", popped[0], 64'h300);

        // asynchronous reset with two entries buffered
        do_reset();
        for (int k = 0; k < 20 && bus.count != 3'd2; k++)
            tick();
        check64("t6_count_before", 64'(bus.count), 64'd2);
        rst = 1'b1;
        #1;
        check_reset_outputs("t6");
        do_reset();
        bus.out_ready = 1'b1;
        run_until_pops("t6", 2, 20);
        if (popped.size() >= 2) begin
            check64("t6_pc0", popped[0], 64'h0);
            check64("t6_pc1", popped[1], 64'h4);
        end

        // redirect vectors across latencies, including 64-bit wrap
        for (int i = 0; i < 5; i++) begin
            do_reset();
            lat = tbl[i].lat;
            bus.out_ready = 1'b1;
            repeat (6) tick();
            bus.redirect = 1'b1;
            bus.redirect_pc = tbl[i].target;
            tick();
            bus.redirect = 1'b0;
            popped.delete();
            run_until_pops("vec", 2, 60);
            if (popped.size() >= 2) begin
                check64("vec_pc0", popped[0], tbl[i].e0);
                check64("vec_pc1", popped[1], tbl[i].e1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
